// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial add controller.
//   - state_t : 2-bit FSM state encoding (IDLE / RUN / DONE)
// Optional feature macro used by serial_add_ctrl: SERIAL_ADD_SUB_EN
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : serial_add_pkg

// File: rtl/serial_fa_cell.sv
// serial_fa_cell
//   Combinational 1-bit full adder; the single arithmetic cell that the
//   serial controller reuses on every bit.
//   Ports:
//     x, y  in  1  operand bits
//     cin   in  1  carry in
//     s     out 1  sum bit
//     cout  out 1  carry out
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Plain sum / majority-carry equations of a full adder.
  always_comb begin
    s    = x ^ y ^ cin;
    cout = (x & y) | (x & cin) | (y & cin);
  end

endmodule : serial_fa_cell

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder: one full-adder cell sequenced over WIDTH cycles,
//   LSB first, wrapped in a start/busy/done handshake.
//   Parameters:
//     WIDTH  operand/result width (2..64)
//   Ports:
//     clk    in  1      rising-edge clock
//     rst    in  1      asynchronous active-high reset
//     start  in  1      request, honoured only in IDLE
//     a, b   in  WIDTH  operands, captured on the accepting edge
//     sub    in  1      subtract select (only with SERIAL_ADD_SUB_EN)
//     busy   out 1      high while the bits are being processed
//     done   out 1      one-cycle completion pulse
//     sum    out WIDTH  registered result, held until the next completion
//     car    out 1      registered carry-out (no-borrow flag when subtracting)
//   Configuration macro: SERIAL_ADD_SUB_EN adds the sub port and a-b mode.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             car
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             cy;

  logic             cell_s;
  logic             cell_c;

  logic [WIDTH-1:0] load_b;
  logic             load_cy;

  // The shared cell always sees the current LSBs and the carry flop.
  serial_fa_cell u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .cin  (cy),
    .s    (cell_s),
    .cout (cell_c)
  );

  // Operand-B and carry seed chosen at accept time; subtraction is
  // a + ~b + 1, so the inverted operand pairs with a carry seed of 1.
`ifdef SERIAL_ADD_SUB_EN
  always_comb begin
    load_b  = sub ? ~b : b;
    load_cy = sub;
  end
`else
  always_comb begin
    load_b  = b;
    load_cy = 1'b0;
  end
`endif

  // Whole controller: FSM, datapath shift registers and registered outputs.
  // The counter stops at the last bit rather than incrementing so it never
  // wraps; sum/car only load on the RUN->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      car   <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            sa    <= a;
            sb    <= load_b;
            cy    <= load_cy;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          sa <= sa >> 1;
          sb <= sb >> 1;
          sr <= {cell_s, sr[WIDTH-1:1]};
          cy <= cell_c;
          if (cnt == LAST_BIT) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= {cell_s, sr[WIDTH-1:1]};
            car   <= cell_c;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed self-checking bench for serial_add_ctrl at WIDTH=8.
//   Subtraction vectors are exercised when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         car;

  int tests_run;
  int tests_failed;

  // Last result the DUT should be holding on sum/car.
  logic [W-1:0] last_sum;
  logic         last_car;

  // Directed vector table: a, b, sub, expected sum, expected carry.
  logic [W-1:0] va   [6] = '{8'h00, 8'h5A, 8'hFF, 8'h12, 8'h10, 8'h01};
  logic [W-1:0] vb   [6] = '{8'h00, 8'h3C, 8'h01, 8'h34, 8'h01, 8'h02};
  logic         vs   [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
  logic [W-1:0] vsum [6] = '{8'h00, 8'h96, 8'h00, 8'h46, 8'h0F, 8'hFF};
  logic         vcar [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .car   (car)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request inputs; takes effect on the next rising edge.
  task automatic applyStimulus(input logic s, input logic [W-1:0] av,
                               input logic [W-1:0] bv, input logic sv);
    start = s;
    a     = av;
    b     = bv;
    sub   = sv;
  endtask

  // Reset values on all outputs.
  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    tests_run++;
    if ({busy, done, car, sum} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b car=%b sum=%h, expected 0 0 0 00",
               busy, done, car, sum);
    end
    rst = 1'b0;
    tick();
    last_sum = 8'h00;
    last_car = 1'b0;
  endtask

  // Run table entries [first, first+count) with full cycle-by-cycle checks.
  task automatic test_vectors(input int first, input int count);
    for (int v = first; v < first + count; v++) begin
      applyStimulus(1'b1, va[v], vb[v], vs[v]);
      tick();                                  // accepting edge k
      applyStimulus(1'b0, 8'hA5, 8'h5A, 1'b0); // operands now don't-care
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL vec%0d_accept: got busy=%b done=%b, expected 1 0", v, busy, done);
      end
      for (int c = 1; c < W; c++) begin
        tick();
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== last_sum || car !== last_car) begin
          tests_failed++;
          $display("[TB] FAIL vec%0d_run_c%0d: got busy=%b done=%b sum=%h car=%b, expected 1 0 %h %b",
                   v, c, busy, done, sum, car, last_sum, last_car);
        end
      end
      tick();                                  // edge k+W
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b1 || sum !== vsum[v] || car !== vcar[v]) begin
        tests_failed++;
        $display("[TB] FAIL vec%0d_done: got busy=%b done=%b sum=%h car=%b, expected 0 1 %h %b",
                 v, busy, done, sum, car, vsum[v], vcar[v]);
      end
      tick();                                  // edge k+W+1
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== vsum[v] || car !== vcar[v]) begin
        tests_failed++;
        $display("[TB] FAIL vec%0d_after: got busy=%b done=%b sum=%h car=%b, expected 0 0 %h %b",
                 v, busy, done, sum, car, vsum[v], vcar[v]);
      end
      last_sum = vsum[v];
      last_car = vcar[v];
    end
  endtask

  // start held high with operands changing every cycle: only the accepting
  // edges (0 and 10) capture operands.
  task automatic test_held_start();
    applyStimulus(1'b1, 8'h21, 8'h43, 1'b0);
    tick();                                    // edge 0
    for (int c = 1; c < W; c++) begin
      applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
      tick();
      tests_run++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL held_run1_c%0d: got busy=%b done=%b, expected 1 0", c, busy, done);
      end
    end
    applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
    tick();                                    // edge 8
    tests_run++;
    if (done !== 1'b1 || sum !== 8'h64 || car !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL held_done1: got done=%b sum=%h car=%b, expected 1 64 0", done, sum, car);
    end
    applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
    tick();                                    // edge 9: back in IDLE, not yet accepted
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL held_gap: got busy=%b done=%b, expected 0 0", busy, done);
    end
    applyStimulus(1'b1, 8'hC8, 8'h64, 1'b0);
    tick();                                    // edge 10: second accept
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL held_accept2: got busy=%b, expected 1", busy);
    end
    for (int c = 1; c < W; c++) begin
      applyStimulus(1'b1, W'($urandom), W'($urandom), 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();                                    // edge 18
    tests_run++;
    if (done !== 1'b1 || sum !== 8'h2C || car !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL held_done2: got done=%b sum=%h car=%b, expected 1 2c 1", done, sum, car);
    end
    tick();
    last_sum = 8'h2C;
    last_car = 1'b1;
  endtask

  // Reset after 3 processed bits aborts everything and clears the result;
  // no late done pulse may follow.
  task automatic test_reset_mid_run();
    int seen_done;
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0);
    tick();
    tick();
    tick();                                    // three bits processed
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, car, sum} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("[TB] FAIL midrun_reset: got busy=%b done=%b car=%b sum=%h, expected 0 0 0 00",
               busy, done, car, sum);
    end
    tick();
    rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < W + 4; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    tests_run++;
    if (seen_done != 0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_no_pulse: got %0d active cycles, expected 0", seen_done);
    end
    last_sum = 8'h00;
    last_car = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    #2;

    test_reset();
    test_vectors(0, 3);       // 00+00, 5A+3C, FF+01 (sum holds 96 during last run)
    test_held_start();
    test_reset_mid_run();
    test_vectors(3, 1);       // 12+34 after the abort
`ifdef SERIAL_ADD_SUB_EN
    test_vectors(4, 2);       // 10-01, 01-02
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_serial_add_ctrl

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add controller. It sequences a single shared 1-bit full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands, one bit per cycle, LSB first. A start/busy/done handshake wraps the sequencing, and the result is held on registered outputs. The block sits beside the project-2 adder cells as the sequential alternative to a ripple-carry word adder: one adder cell plus state, instead of WIDTH cells.

## Interface
- WIDTH, 16, operand and result width in bits; legal range 2..64.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse, high while in DONE.
- sum  out  WIDTH  registered result.
- car  out  1  registered carry-out (bit WIDTH).
- sub  in  1  subtract select; present only with SERIAL_ADD_SUB_EN.

## Operation
- States:
  - IDLE: default state.
  - RUN: processes one bit per cycle.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- IDLE -> RUN on start=1:
  - Load shift register sa<=a and sb<=b.
  - Clear the carry flop.
  - Set bit counter cnt<=0.
- Each RUN cycle:
  - Feed sa[0], sb[0] and the carry flop to the cell.
  - Shift sa and sb right by one.
  - Shift the cell's sum bit into result shift register sr at the MSB.
  - Carry flop <= cell carry.
  - cnt<=cnt+1.
- RUN -> DONE on the edge that processes bit WIDTH-1 (cnt==WIDTH-1). On that same edge: sum<=final sr, car<=final carry.
- DONE -> IDLE unconditionally.
- start is ignored in RUN and DONE, including when held high. The operand inputs are don't-care outside the accepting edge.
- sum and car change only on the RUN->DONE edge, or on reset. They hold their value through later IDLE periods and the next RUN.
- Arithmetic is modulo 2^WIDTH. car is the true carry-out.
- cnt width is $clog2(WIDTH). cnt never wraps, because the exit happens at WIDTH-1.
- Reset values: state=IDLE, busy=0, done=0, sum=0, car=0, sa=sb=sr=0, cnt=0, carry flop=0.
- Reset asserted mid-RUN or in DONE:
  - Aborts immediately, with no done pulse.
  - The partial result is discarded.
  - sum and car go to 0.

## Timing
- Start is accepted at edge k.
- busy is high from edge k to edge k+WIDTH, which is WIDTH cycles.
- done is high from edge k+WIDTH to edge k+WIDTH+1. sum and car are valid from edge k+WIDTH.
- The earliest next accepted start is edge k+WIDTH+2, so throughput is one add per WIDTH+2 cycles.
- busy and done are never high together.
- Outputs are decoded from state registers only. There is no combinational path from input to output.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - Adds the sub input port, sampled with start.
  - When sub=1 on the accepted edge: sb<=~b and the carry flop is initialised to 1. The result is a-b mod 2^WIDTH.
  - car=1 means no borrow (a>=b unsigned).
  - sub=0 behaves exactly as addition.
- SERIAL_ADD_SUB_EN undefined:
  - There is no sub port.
  - The carry flop always initialises to 0 and the operands are not inverted.

## Structure
- Package serial_add_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10;
  - a 2-bit state typedef.
- Sub-module serial_fa_cell is the combinational 1-bit full adder (x, y, cin -> s, cout), instantiated exactly once. All registers live in serial_add_ctrl.

## Test plan
All scenarios use WIDTH=8.
- Reset, then start with a=8'h00, b=8'h00 -> busy high 8 cycles, done pulses 1 cycle at edge 8, sum=8'h00, car=0.
- a=8'h5A, b=8'h3C -> sum=8'h96, car=0. Also a=8'hFF, b=8'h01 -> sum=8'h00, car=1 (wrap-around).
- Hold start=1 continuously and change a/b every cycle during RUN:
  - only the first accept counts;
  - the next accept is at edge 10;
  - sum always matches the operands captured at each accept.
- Assert rst during RUN after 3 bits -> busy=0, done=0, sum=0, car=0 immediately, and no done pulse. A following start with 8'h12+8'h34 -> sum=8'h46.
- Previous result 8'h96, new start -> sum stays 8'h96 through RUN and updates only on the done edge.
- With SERIAL_ADD_SUB_EN, sub=1:
  - 8'h10-8'h01 -> sum=8'h0F, car=1;
  - 8'h01-8'h02 -> sum=8'hFF, car=0.
